run_controller: RTL

- Sequences program execution on the fetch unit: selects one of four program entry points, pulses the PC start/load for one cycle, then runs until a halt instruction or a cycle-budget timeout.
- Reports completion with a done/ack handshake and an executed-instruction count.
- Sits between the host/testbench control interface and fetch_unit. It drives start/start_addr and observes instr_out.

---
 rtl/emu_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 29 ++
 rtl/run_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/emu_ctrl_pkg.sv
// Shared types and constants for the program run controller.
package emu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } run_state_t;

  localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;

  // One extra address bit lets the PC point one past the end of the ROM.
  function automatic int addr_width(input int rom_size);
    return $clog2(rom_size) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter that never wraps; hit flags that the next increment lands on limit.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_inc;

  assign count_inc = count + W'(1);
  assign hit       = en && (count_inc == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Launches a program on the fetch unit, runs it until halt or budget timeout,
// then holds done until acknowledged.
module run_controller
  import emu_ctrl_pkg::*;
#(
  parameter int                  ROM_SIZE   = 512,
  parameter int                  INSTR_W    = 9,
  parameter int                  CNT_W      = 16,
  localparam int                 ADDR_W     = addr_width(ROM_SIZE),
  parameter logic [CNT_W-1:0]    MAX_CYCLES = CNT_W'(16'hFFFF),
  parameter logic [INSTR_W-1:0]  HALT_INSTR = INSTR_W'(HALT_INSTR_DEFAULT),
  parameter logic [ADDR_W-1:0]   PROG0_ADDR = '0,
  parameter logic [ADDR_W-1:0]   PROG1_ADDR = '0,
  parameter logic [ADDR_W-1:0]   PROG2_ADDR = '0,
  parameter logic [ADDR_W-1:0]   PROG3_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic [1:0]         prog_sel,
  input  logic               abort,
  input  logic               done_ack,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               start,
  output logic [ADDR_W-1:0]  start_addr,
  output logic               run_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
);

  run_state_t        state_reg;
  logic [ADDR_W-1:0] entry_addr;
  logic              is_halt;
  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_hit;

  always_comb begin
    entry_addr = PROG0_ADDR;
    case (prog_sel)
      2'd0: entry_addr = PROG0_ADDR;
      2'd1: entry_addr = PROG1_ADDR;
      2'd2: entry_addr = PROG2_ADDR;
      2'd3: entry_addr = PROG3_ADDR;
      default: entry_addr = PROG0_ADDR;
    endcase
  end

  assign is_halt   = (instr_in == HALT_INSTR);
  assign cnt_clear = (state_reg == IDLE) && run_req;
  // Abort and halt both outrank counting, so the halting instruction is never counted.
  assign cnt_en    = (state_reg == RUN) && !abort && !is_halt;

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_counter (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .en   (cnt_en),
    .limit(MAX_CYCLES),
    .count(cycle_count),
    .hit  (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      start      <= 1'b0;
      start_addr <= '0;
      run_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run_req) begin
            state_reg  <= LAUNCH;
            start      <= 1'b1;
            busy       <= 1'b1;
            start_addr <= entry_addr;
            timeout    <= 1'b0;
          end
        end
        LAUNCH: begin
          start <= 1'b0;
          if (abort) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg <= RUN;
            run_en    <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            run_en    <= 1'b0;
            busy      <= 1'b0;
          end else if (is_halt || cnt_hit) begin
            state_reg <= DONE;
            run_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= !is_halt;
          end
        end
        DONE: begin
          if (done_ack || abort) begin
            state_reg <= IDLE;
            done      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          start     <= 1'b0;
          run_en    <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
